// File: rtl/counter_pkg.sv
// Shared types and elaboration-time helpers for the up/down counter family.
package counter_pkg;

  // Count direction, matching the encoding of the 'up' input pin.
  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int clog2(input longint value);
    int     bits;
    longint rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

  // Highest count value reachable for a given modulus.
  function automatic longint max_count(input longint modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step on the last one.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_direct
      // Every enabled cycle is a step, so no state is kept; the clock and
      // reset are tied off so the port list stays uniform across PRESCALE values.
      logic unused_inputs;
      assign unused_inputs = clk ^ reset;
      assign step = en & ~restart;
    end else begin : g_divide
      localparam int PW = clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre;

      // Counts enabled cycles; a low enable freezes it, restart zeroes it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pre <= '0;
        end else if (restart) begin
          pre <= '0;
        end else if (en) begin
          if (pre == LAST) begin
            pre <= '0;
          end else begin
            pre <= pre + PW'(1);
          end
        end
      end

      assign step = en & ~restart & (pre == LAST);
    end
  endgenerate

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with prescaler, load/clear, wrap or
// saturate, a registered terminal-count pulse and a sticky overflow flag.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Bound kept one bit wider so MODULUS == 2**WIDTH never relies on wraparound.
  localparam logic [WIDTH:0] MAXC = (WIDTH + 1)'(max_count(MODULUS));

  logic             step;
  logic             restart;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             at_max;
  logic             at_zero;
  logic             load_oor;
  cnt_dir_e         dir;

  assign restart  = clear | load;
  assign dir      = cnt_dir_e'(up);
  assign at_max   = ({1'b0, count} == MAXC);
  assign at_zero  = (count == '0);
  assign load_oor = ({1'b0, load_val} > MAXC);

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .restart(restart),
    .step   (step)
  );

  // Next-state selection: clear beats load beats step; bounds are checked
  // before any arithmetic so the add/subtract never leaves 0..MODULUS-1.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (clear) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      if (load_oor) begin
        count_nxt = MAXC[WIDTH-1:0];
        ovf_nxt   = 1'b1;
      end else begin
        count_nxt = load_val;
      end
    end else if (step) begin
      if (dir == CNT_UP) begin
        if (at_max) begin
          count_nxt = sat ? count : '0;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          count_nxt = sat ? count : MAXC[WIDTH-1:0];
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // Output registers; everything the outside world sees comes from here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule
